// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Memory RW line polarity: high reads, low writes
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Port indices used for grant and last_grant
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/dmem_arb_if.sv
// rtl/dmem_arb_if.sv - one requester port of the data-memory arbiter
interface dmem_arb_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  // Requester side
  modport master (output req, we, addr, wdata, input ack, rdata);
  // Arbiter side
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - winner select; round-robin when DMEM_ARB_RR_EN is defined
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic grant
);

`ifdef DMEM_ARB_RR_EN
  // On a tie the port that was not served last wins
  always_comb begin
    valid = req0 | req1;
    grant = PORT_CPU;
    if (req0 && req1) begin
      grant = (last_grant == PORT_CPU) ? PORT_AUX : PORT_CPU;
    end else if (req1) begin
      grant = PORT_AUX;
    end
  end
`else
  // last_grant is tracked by the top but has no effect on fixed priority
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Fixed priority: port 0 wins any tie
  always_comb begin
    valid = req0 | req1;
    grant = PORT_CPU;
    if (!req0 && req1) begin
      grant = PORT_AUX;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter, IDLE/ACCESS/DONE FSM (option: DMEM_ARB_RR_EN)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          ck,
  input  logic          rst_n,
  dmem_arb_if.slave     p0,
  dmem_arb_if.slave     p1,
  output logic [AW-1:0] da,
  output logic [DW-1:0] ddo,
  input  logic [DW-1:0] ddi,
  output logic          rw,
  output logic          busy
);

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [AW-1:0] da_q, da_d;
  logic [DW-1:0] ddo_q, ddo_d;
  logic          rw_q, rw_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          busy_q, busy_d;

  logic          pick_valid;
  logic          pick_grant;

  dmem_arb_pick u_pick (
    .req0       (p0.req),
    .req1       (p1.req),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  // State and all output registers; reset forces RW high at once so a write in flight is dropped
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_AUX;
      da_q         <= '0;
      ddo_q        <= '0;
      rw_q         <= RW_READ;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      da_q         <= da_d;
      ddo_q        <= ddo_d;
      rw_q         <= rw_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
    end
  end

  // Next state and next register values; last_grant doubles as the current grant during ACCESS/DONE
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    da_d         = da_q;
    ddo_d        = ddo_q;
    rw_d         = rw_q;
    ack0_d       = ack0_q;
    ack1_d       = ack1_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      IDLE: begin
        rw_d = RW_READ;
        if (pick_valid) begin
          last_grant_d = pick_grant;
          if (pick_grant == PORT_AUX) begin
            da_d  = p1.addr;
            ddo_d = p1.wdata;
            rw_d  = ~p1.we;
          end else begin
            da_d  = p0.addr;
            ddo_d = p0.wdata;
            rw_d  = ~p0.we;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (last_grant_q == PORT_AUX) begin
          ack1_d = 1'b1;
          if (rw_q == RW_READ) rdata1_d = ddi;
        end else begin
          ack0_d = 1'b1;
          if (rw_q == RW_READ) rdata0_d = ddi;
        end
        rw_d    = RW_READ;
        state_d = DONE;
      end
      DONE: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        rw_d    = RW_READ;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign da       = da_q;
  assign ddo      = ddo_q;
  assign rw       = rw_q;
  assign busy     = busy_q;
  assign p0.ack   = ack0_q;
  assign p1.ack   = ack1_q;
  assign p0.rdata = rdata0_q;
  assign p1.rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] da;
  logic [15:0] ddo;
  logic [15:0] ddi = 16'h0000;
  logic        rw;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wcount = 0;
  int cyc = 0;
  bit mem_init = 1'b0;
  logic [15:0] mem [0:65535];

  dmem_arb_if #(.AW(16), .DW(16)) p0_if ();
  dmem_arb_if #(.AW(16), .DW(16)) p1_if ();

  dmem_arbiter #(.AW(16), .DW(16)) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .p0    (p0_if),
    .p1    (p1_if),
    .da    (da),
    .ddo   (ddo),
    .ddi   (ddi),
    .rw    (rw),
    .busy  (busy)
  );

  always #5 ck = ~ck;

  always @(posedge ck) cyc++;

  // Negedge memory: write when RW is low, then present DMEM[DA]
  always @(negedge ck) begin
    if (!mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      mem[7] = 16'h1234;
      mem_init = 1'b1;
    end
    if (rw === 1'b0) begin
      mem[da] = ddo;
      wcount++;
    end
    ddi = mem[da];
  end

  task automatic tick;
    @(posedge ck);
    #1;
  endtask

  task automatic clear_reqs;
    p0_if.req = 1'b0; p0_if.we = 1'b0; p0_if.addr = 16'h0; p0_if.wdata = 16'h0;
    p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.addr = 16'h0; p1_if.wdata = 16'h0;
  endtask

  task automatic test_reset;
    int w0;
    int acks;
    clear_reqs();
    repeat (2) @(posedge ck);
    #1;
    checks++;
    if (da !== 16'h0 || ddo !== 16'h0 || rw !== 1'b1 || busy !== 1'b0 ||
        p0_if.ack !== 1'b0 || p1_if.ack !== 1'b0 ||
        p0_if.rdata !== 16'h0 || p1_if.rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_values: da=%h ddo=%h rw=%b busy=%b ack=%b%b rd0=%h rd1=%h, want all 0 except rw=1",
               da, ddo, rw, busy, p0_if.ack, p1_if.ack, p0_if.rdata, p1_if.rdata);
    end
    rst_n = 1'b1;
    tick();
    p0_if.req = 1'b1; p0_if.we = 1'b1; p0_if.addr = 16'h0003; p0_if.wdata = 16'hBEEF;
    w0 = wcount;
    tick();
    checks++;
    if (rw !== 1'b0 || da !== 16'h0003) begin
      errors++;
      $display("FAIL reset_pre_access: rw=%b da=%h, want rw=0 da=0003", rw, da);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rw !== 1'b1 || busy !== 1'b0 || da !== 16'h0 || ddo !== 16'h0 || p0_if.ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: rw=%b busy=%b da=%h ddo=%h ack0=%b, want 1 0 0000 0000 0", rw, busy, da, ddo, p0_if.ack);
    end
    clear_reqs();
    tick();
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (p0_if.ack === 1'b1 || p1_if.ack === 1'b1) acks++;
    end
    checks++;
    if (acks !== 0 || mem[3] !== 16'h0000 || wcount !== w0) begin
      errors++;
      $display("FAIL reset_abort: acks=%0d mem3=%h writes=%0d, want 0 0000 0", acks, mem[3], wcount - w0);
    end
  endtask

  task automatic test_write_read_p0;
    int w0;
    w0 = wcount;
    p0_if.req = 1'b1; p0_if.we = 1'b1; p0_if.addr = 16'h0000; p0_if.wdata = 16'h0004;
    tick();
    checks++;
    if (rw !== 1'b0 || da !== 16'h0000 || ddo !== 16'h0004 || busy !== 1'b1 || p0_if.ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_access: rw=%b da=%h ddo=%h busy=%b ack0=%b, want 0 0000 0004 1 0", rw, da, ddo, busy, p0_if.ack);
    end
    tick();
    checks++;
    if (p0_if.ack !== 1'b1 || rw !== 1'b1 || p1_if.ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_ack: ack0=%b ack1=%b rw=%b, want 1 0 1", p0_if.ack, p1_if.ack, rw);
    end
    p0_if.req = 1'b0;
    tick();
    checks++;
    if (p0_if.ack !== 1'b0 || busy !== 1'b0 || mem[0] !== 16'h0004 || wcount - w0 !== 1) begin
      errors++;
      $display("FAIL wr_done: ack0=%b busy=%b mem0=%h writes=%0d, want 0 0 0004 1", p0_if.ack, busy, mem[0], wcount - w0);
    end
    p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 16'h0000;
    tick();
    checks++;
    if (rw !== 1'b1 || da !== 16'h0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rd_access: rw=%b da=%h busy=%b, want 1 0000 1", rw, da, busy);
    end
    tick();
    checks++;
    if (p0_if.ack !== 1'b1 || p0_if.rdata !== 16'h0004) begin
      errors++;
      $display("FAIL rd_data0: ack0=%b rdata0=%h, want 1 0004", p0_if.ack, p0_if.rdata);
    end
    p0_if.req = 1'b0;
    tick();
  endtask

  task automatic test_p1_read;
    p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.addr = 16'h0007;
    tick();
    tick();
    checks++;
    if (p1_if.ack !== 1'b1 || p0_if.ack !== 1'b0 || p1_if.rdata !== 16'h1234 || p0_if.rdata !== 16'h0004) begin
      errors++;
      $display("FAIL p1_read: ack1=%b ack0=%b rdata1=%h rdata0=%h, want 1 0 1234 0004",
               p1_if.ack, p0_if.ack, p1_if.rdata, p0_if.rdata);
    end
    p1_if.req = 1'b0;
    tick();
  endtask

  task automatic test_arbitration;
    logic [3:0] want;
`ifdef DMEM_ARB_RR_EN
    want = 4'b1010;
`else
    want = 4'b0000;
`endif
    p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 16'h0007;
    p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.addr = 16'h0000;
    for (int t = 0; t < 4; t++) begin
      tick();
      tick();
      checks++;
      if (p1_if.ack !== want[t] || p0_if.ack !== ~want[t]) begin
        errors++;
        $display("FAIL arb_grant%0d: ack0=%b ack1=%b, want ack1=%b ack0=%b", t, p0_if.ack, p1_if.ack, want[t], ~want[t]);
      end
      tick();
    end
    checks++;
    if (p0_if.rdata !== 16'h1234 || p1_if.rdata !== (want[1] ? 16'h0004 : 16'h1234)) begin
      errors++;
      $display("FAIL arb_rdata: rdata0=%h rdata1=%h, want 1234 %h", p0_if.rdata, p1_if.rdata, want[1] ? 16'h0004 : 16'h1234);
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_late_req;
    p0_if.req = 1'b1; p0_if.we = 1'b1; p0_if.addr = 16'h0005; p0_if.wdata = 16'h00A5;
    tick();
    p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.addr = 16'h0007;
    tick();
    checks++;
    if (p0_if.ack !== 1'b1 || p1_if.ack !== 1'b0) begin
      errors++;
      $display("FAIL late_ack0: ack0=%b ack1=%b, want 1 0", p0_if.ack, p1_if.ack);
    end
    p0_if.req = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || p0_if.ack !== 1'b0 || p1_if.ack !== 1'b0) begin
      errors++;
      $display("FAIL late_wait: busy=%b ack0=%b ack1=%b, want 0 0 0", busy, p0_if.ack, p1_if.ack);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || da !== 16'h0007 || rw !== 1'b1) begin
      errors++;
      $display("FAIL late_grant: busy=%b da=%h rw=%b, want 1 0007 1", busy, da, rw);
    end
    tick();
    checks++;
    if (p1_if.ack !== 1'b1 || p0_if.ack !== 1'b0 || mem[5] !== 16'h00A5) begin
      errors++;
      $display("FAIL late_ack1: ack1=%b ack0=%b mem5=%h, want 1 0 00a5", p1_if.ack, p0_if.ack, mem[5]);
    end
    p1_if.req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    int c1;
    int c2;
    c1 = -1;
    c2 = -1;
    p0_if.req = 1'b1; p0_if.we = 1'b1; p0_if.addr = 16'h0001; p0_if.wdata = 16'hAAAA;
    for (int i = 0; i < 8 && c2 < 0; i++) begin
      tick();
      if (p0_if.ack === 1'b1) begin
        if (c1 < 0) begin
          c1 = cyc;
          p0_if.addr = 16'h0002;
          p0_if.wdata = 16'h5555;
        end else begin
          c2 = cyc;
          p0_if.req = 1'b0;
        end
      end
    end
    checks++;
    if (c1 < 0 || c2 < 0 || c2 - c1 !== 3) begin
      errors++;
      $display("FAIL b2b_spacing: first=%0d second=%0d, want both seen 3 cycles apart", c1, c2);
    end
    p0_if.req = 1'b0;
    tick();
    checks++;
    if (mem[1] !== 16'hAAAA || mem[2] !== 16'h5555) begin
      errors++;
      $display("FAIL b2b_mem: mem1=%h mem2=%h, want aaaa 5555", mem[1], mem[2]);
    end
  endtask

  initial begin
    test_reset();
    test_write_read_p0();
    test_p1_read();
    test_arbitration();
    test_late_req();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
